dac_spi_driver: RTL and testbench

Output stage of the signal generator: takes the registered 8-bit waveform sample chosen by the waveform selector, optionally applies centred amplitude scaling, and streams it at a fixed sample rate as 16-bit SPI frames to an MCP4921-class 12-bit DAC. It sits directly downstream of the selector and is the last block before the FPGA pins.

---
 rtl/dac_pkg.sv | 34 +++
 rtl/dac_amp_scaler.sv | 48 ++++
 rtl/dac_spi_driver.sv | 175 +++++++++++++++++
 tb/tb_dac_spi_driver.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// ============================================================================
// Module      : dac_pkg
// Description : Shared types and constants for the MCP4921-class DAC output
//               stage (frame layout, mid-scale code, driver state encoding).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dac_pkg;

    // Driver sequencing states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        END   = 2'd2
    } dac_state_e;

    // Upper nibble of every frame: write DAC A, unbuffered Vref, 1x gain, active
    localparam logic [3:0] DAC_CTRL_BITS = 4'b0011;

    // Bits per SPI frame
    localparam int DAC_FRAME_W = 16;

    // Offset-binary mid-scale code (zero of the centred waveform)
    localparam logic [7:0] DAC_MID = 8'd128;

    // Build a DAC frame: control nibble, 8-bit code left-justified in 12 bits
    function automatic logic [DAC_FRAME_W-1:0] dac_frame(input logic [7:0] code);
        return {DAC_CTRL_BITS, code, 4'b0000};
    endfunction

endpackage

`default_nettype wire

// File: rtl/dac_amp_scaler.sv
// ============================================================================
// Module      : dac_amp_scaler
// Description : Combinational centred amplitude scaler. With DAC_AMP_SCALE_EN
//               defined: scaled = ((sample - 128) * (gain + 1)) >>> 8 + 128.
//               With DAC_AMP_SCALE_EN undefined the sample passes straight
//               through and gain is ignored (no multiplier is built).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dac_amp_scaler
    import dac_pkg::*;
(
    input  logic [7:0] sample_i,
    input  logic [7:0] gain_i,
    output logic [7:0] scaled_o
);

`ifdef DAC_AMP_SCALE_EN
    // Signed distance from mid-scale: -128..127
    logic signed [8:0]  w_diff;
    // Gain plus one so that 0xFF gives an exact unity multiply by 256
    logic        [9:0]  w_gain_p1;
    // Product range is -32768..32512, comfortably inside 18 signed bits
    logic signed [17:0] w_prod;
    // Bits outside the used window are structurally redundant
    logic               w_unused;

    assign w_diff    = $signed({1'b0, sample_i}) - $signed({1'b0, DAC_MID});
    assign w_gain_p1 = {2'b00, gain_i} + 10'd1;
    // Low 18 bits of an unsigned multiply of the sign-extended operands equal
    // the signed product, since the true result fits in 18 bits
    assign w_prod    = $signed({{9{w_diff[8]}}, w_diff} * {8'd0, w_gain_p1});
    // Arithmetic >>> 8 lands in -128..127, so only bits [15:8] matter and the
    // re-centring add can wrap in 8 bits without any saturation
    assign scaled_o  = w_prod[15:8] + DAC_MID;
    assign w_unused  = ^{w_prod[17:16], w_prod[7:0]};
`else
    // Gain is accepted but has no effect in the unscaled build
    logic w_unused;

    assign scaled_o = sample_i;
    assign w_unused = ^gain_i;
`endif

endmodule

`default_nettype wire

// File: rtl/dac_spi_driver.sv
// ============================================================================
// Module      : dac_spi_driver
// Description : Signal-generator output stage. At a fixed sample rate latches
//               the (optionally scaled) 8-bit sample and shifts it out as a
//               16-bit SPI mode-0 frame to an MCP4921-class DAC, followed by
//               a CLK_DIV-cycle chip-select-high gap. Flags overrun when a
//               sample tick lands while a frame is still in progress.
//               Optional feature macro: DAC_AMP_SCALE_EN (amplitude scaling).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dac_spi_driver
    import dac_pkg::*;
#(
    parameter int CLK_DIV    = 4,    // clk cycles per SCLK half-period, >= 1
    parameter int SAMPLE_DIV = 250   // clk cycles per output sample, >= 2
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [7:0] sample_in,
    input  logic [7:0] gain,
    output logic       dac_cs_n,
    output logic       dac_sclk,
    output logic       dac_din,
    output logic       sample_ack,
    output logic       busy,
    output logic       overrun
);

    localparam int CNT_W = $clog2(SAMPLE_DIV);
    localparam int HC_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(DAC_FRAME_W);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);
    localparam logic [HC_W-1:0]  HC_LAST  = HC_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DAC_FRAME_W - 1);

    dac_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;     // free-running sample-rate counter
    logic [HC_W-1:0]        hc_q, hc_d;       // cycles within an SCLK half / gap
    logic [BIT_W-1:0]       bit_q, bit_d;     // bits already completed in frame
    logic [DAC_FRAME_W-1:0] sr_q, sr_d;       // MSB drives dac_din
    logic                   sclk_q, sclk_d;
    logic                   cs_n_q, cs_n_d;
    logic                   ack_q, ack_d;
    logic                   busy_q, busy_d;
    logic                   ovr_q, ovr_d;

    logic                   w_tick;
    logic [7:0]             w_scaled;
    logic [DAC_FRAME_W-1:0] w_frame;

    dac_amp_scaler u_scaler (
        .sample_i (sample_in),
        .gain_i   (gain),
        .scaled_o (w_scaled)
    );

    assign w_frame = dac_frame(w_scaled);
    assign w_tick  = (cnt_q == CNT_LAST);

    // State and output registers; reset clears everything asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hc_q    <= '0;
            bit_q   <= '0;
            sr_q    <= '0;
            sclk_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hc_q    <= hc_d;
            bit_q   <= bit_d;
            sr_q    <= sr_d;
            sclk_q  <= sclk_d;
            cs_n_q  <= cs_n_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            ovr_q   <= ovr_d;
        end
    end

    // Sample-rate counter, frame sequencing and next-value output decode
    always_comb begin
        state_d = state_q;
        hc_d    = hc_q;
        bit_d   = bit_q;
        sr_d    = sr_q;
        sclk_d  = sclk_q;
        cs_n_d  = cs_n_q;
        ack_d   = 1'b0;
        ovr_d   = ovr_q;

        // Counter wraps regardless of enable so the sample grid never drifts
        cnt_d = w_tick ? '0 : cnt_q + CNT_W'(1);

        // A tick that finds a frame (or its CS gap) in flight is dropped
        if (w_tick && enable && (state_q != IDLE)) begin
            ovr_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (w_tick && enable) begin
                    state_d = SHIFT;
                    sr_d    = w_frame;
                    cs_n_d  = 1'b0;
                    sclk_d  = 1'b0;
                    hc_d    = '0;
                    bit_d   = '0;
                    ack_d   = 1'b1;
                end
            end

            SHIFT: begin
                if (hc_q == HC_LAST) begin
                    hc_d = '0;
                    if (!sclk_q) begin
                        // End of low half: DAC samples din on this rise
                        sclk_d = 1'b1;
                    end else begin
                        // End of high half: falling edge advances din
                        sclk_d = 1'b0;
                        sr_d   = {sr_q[DAC_FRAME_W-2:0], 1'b0};
                        if (bit_q == BIT_LAST) begin
                            state_d = END;
                            cs_n_d  = 1'b1;
                        end else begin
                            bit_d = bit_q + BIT_W'(1);
                        end
                    end
                end else begin
                    hc_d = hc_q + HC_W'(1);
                end
            end

            END: begin
                // Hold CS high for one half-period before accepting a new tick
                if (hc_q == HC_LAST) begin
                    hc_d    = '0;
                    state_d = IDLE;
                end else begin
                    hc_d = hc_q + HC_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                cs_n_d  = 1'b1;
                sclk_d  = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign dac_cs_n   = cs_n_q;
    assign dac_sclk   = sclk_q;
    assign dac_din    = sr_q[DAC_FRAME_W-1];
    assign sample_ack = ack_q;
    assign busy       = busy_q;
    assign overrun    = ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_dac_spi_driver.sv
// ============================================================================
// Module      : tb_dac_spi_driver
// Description : Self-checking bench for dac_spi_driver. A timeline model
//               predicts every output each cycle; directed frames pin the
//               model with hand-computed literals. A second instance with
//               SAMPLE_DIV=100 exercises overrun.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dac_spi_driver;

    localparam int CK  = 4;
    localparam int SD  = 250;
    localparam int SD2 = 100;

`ifdef DAC_AMP_SCALE_EN
    localparam logic [15:0] E_FF = 16'h3BF0;
    localparam logic [15:0] E_00 = 16'h3400;
    localparam logic [15:0] E_80 = 16'h3800;
    localparam logic [15:0] E_3C = 16'h37F0;
`else
    localparam logic [15:0] E_FF = 16'h3FF0;
    localparam logic [15:0] E_00 = 16'h3000;
    localparam logic [15:0] E_80 = 16'h3800;
    localparam logic [15:0] E_3C = 16'h33C0;
`endif

    logic       clk, rst_n, enable, enable2;
    logic [7:0] sample_in, gain, sample2, gain2;
    logic       dac_cs_n, dac_sclk, dac_din, sample_ack, busy, overrun;
    logic       cs2_n, sclk2, din2, ack2, busy2, ovr2;

    dac_spi_driver #(.CLK_DIV(CK), .SAMPLE_DIV(SD)) u_dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .sample_in(sample_in), .gain(gain),
        .dac_cs_n(dac_cs_n), .dac_sclk(dac_sclk), .dac_din(dac_din),
        .sample_ack(sample_ack), .busy(busy), .overrun(overrun)
    );

    dac_spi_driver #(.CLK_DIV(CK), .SAMPLE_DIV(SD2)) u_ovr (
        .clk(clk), .rst_n(rst_n), .enable(enable2), .sample_in(sample2), .gain(gain2),
        .dac_cs_n(cs2_n), .dac_sclk(sclk2), .dac_din(din2),
        .sample_ack(ack2), .busy(busy2), .overrun(ovr2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected 8-bit DAC code for a sample/gain pair, straight from the scaling rule
    function automatic logic [7:0] model_scale(input logic [7:0] s, input logic [7:0] g);
`ifdef DAC_AMP_SCALE_EN
        int d;
        int p;
        d = int'(s) - 128;
        p = d * (int'(g) + 1);
        return 8'((p >>> 8) + 128);   // floor division by 256, then re-centre
`else
        logic [7:0] unused_g;
        unused_g = g;
        return s;
`endif
    endfunction

    // ---------------- timeline model of the main instance ----------------
    int          m_cnt = 0;
    int          m_off = 0;
    bit          m_active = 0;
    bit          m_ovr = 0;
    bit          m_tick, m_was;
    logic [15:0] m_frame = '0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_cnt = 0; m_off = 0; m_active = 0; m_ovr = 0;
        end else begin
            m_tick = (m_cnt == SD - 1);
            m_cnt  = m_tick ? 0 : m_cnt + 1;
            m_was  = m_active;
            if (m_active) begin
                m_off++;
                if (m_off == 33 * CK) m_active = 0;
            end
            if (m_tick && enable) begin
                if (m_was) m_ovr = 1;
                else begin
                    m_active = 1;
                    m_off    = 0;
                    m_frame  = {4'b0011, model_scale(sample_in, gain), 4'b0000};
                end
            end
        end
    end

    // Per-cycle compare of {cs_n, sclk, din, ack, busy, overrun} against the model
    logic [5:0] exp_v, act_v;
    logic       e_cs, e_sclk, e_din, a_din;
    initial forever begin
        @(negedge clk);
        a_din = dac_din;
        if (!rst_n) begin
            e_cs = 1'b1; e_sclk = 1'b0; e_din = 1'b0;
        end else if (m_active && m_off < 32 * CK) begin
            e_cs   = 1'b0;
            e_sclk = ((m_off / CK) % 2) == 1;
            e_din  = m_frame[15 - m_off / (2 * CK)];
        end else begin
            e_cs = 1'b1; e_sclk = 1'b0; e_din = 1'b0; a_din = 1'b0;  // din unconstrained
        end
        exp_v = {e_cs, e_sclk, e_din, rst_n && m_active && (m_off == 0),
                 rst_n && m_active, rst_n && m_ovr};
        act_v = {dac_cs_n, dac_sclk, a_din, sample_ack, busy, overrun};
        chk("model_cycle", {26'd0, act_v}, {26'd0, exp_v});
    end

    // ---------------- observation helpers ----------------
    int          cs_run = 0, cs_len = 0, busy_run = 0, busy_len = 0, busy_done = 0;
    int          cs_falls = 0, acks2 = 0;
    logic        cs_prev = 1'b1;
    initial forever begin
        @(negedge clk);
        if (!dac_cs_n) cs_run++;
        else if (cs_run > 0) begin cs_len = cs_run; cs_run = 0; end
        if (busy) busy_run++;
        else if (busy_run > 0) begin busy_len = busy_run; busy_run = 0; busy_done++; end
        if (cs_prev && !dac_cs_n) cs_falls++;
        cs_prev = dac_cs_n;
        if (ack2) acks2++;
    end

    logic [15:0] cap = '0, last_frame = '0, cap2 = '0, last2 = '0;
    int          nbits = 0, last_nbits = 0, nbits2 = 0, last_nbits2 = 0, frames2 = 0;
    initial forever begin @(posedge dac_sclk); cap = {cap[14:0], dac_din}; nbits++; end
    initial forever begin @(negedge dac_cs_n); cap = '0; nbits = 0; end
    initial forever begin @(posedge dac_cs_n); last_frame = cap; last_nbits = nbits; end
    initial forever begin @(posedge sclk2); cap2 = {cap2[14:0], din2}; nbits2++; end
    initial forever begin @(negedge cs2_n); cap2 = '0; nbits2 = 0; end
    initial forever begin @(posedge cs2_n); last2 = cap2; last_nbits2 = nbits2; frames2++; end

    task automatic wait_ack(input string name, input int maxc, output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (!sample_ack && n < maxc);
        if (!sample_ack) begin
            checks++; errors++;
            $display("FAIL %s: sample_ack not seen within %0d cycles", name, maxc);
        end
    endtask

    task automatic wait_busy_done(input string name, input int maxc);
        int start;
        int n;
        start = busy_done;
        n = 0;
        while (busy_done == start && n < maxc) begin @(negedge clk); n++; end
        if (busy_done == start) begin
            checks++; errors++;
            $display("FAIL %s: busy did not fall within %0d cycles", name, maxc);
        end
    endtask

    task automatic run_frame(input string name, input logic [7:0] s, input logic [7:0] g,
                             input logic [15:0] exp);
        int n;
        sample_in = s;
        gain      = g;
        wait_ack(name, 2 * SD, n);
        sample_in = ~s;   // only the tick-edge value may matter
        wait_busy_done(name, 400);
        chk({name, "_frame"}, {16'd0, last_frame}, {16'd0, exp});
        chk({name, "_bits"}, last_nbits, 16);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    int n;
    int falls0, base2, w;
    initial begin
        rst_n = 1'b0; enable = 1'b1; enable2 = 1'b0;
        sample_in = 8'hA5; gain = 8'hFF; sample2 = 8'h81; gain2 = 8'hFF;
        repeat (5) @(negedge clk);
        chk("reset_outputs", {26'd0, dac_cs_n, dac_sclk, dac_din, sample_ack, busy, overrun}, 32'h20);
        chk("reset_outputs2", {26'd0, cs2_n, sclk2, din2, ack2, busy2, ovr2}, 32'h20);
        rst_n = 1'b1;

        // First frame: tick on the SAMPLE_DIV-th edge after release
        wait_ack("first_tick", SD + 50, n);
        chk("first_tick_latency", n, SD);
        sample_in = 8'h5A;
        wait_busy_done("unity", 400);
        chk("unity_frame", {16'd0, last_frame}, 32'h3A50);
        chk("unity_bits", last_nbits, 16);
        chk("unity_cs_len", cs_len, 128);
        chk("unity_busy_len", busy_len, 132);

        run_frame("scale_ff", 8'hFF, 8'h7F, E_FF);
        run_frame("scale_00", 8'h00, 8'h7F, E_00);
        run_frame("scale_80", 8'h80, 8'h7F, E_80);
        run_frame("gain_zero", 8'h3C, 8'h00, E_3C);

        // enable falls mid-frame: frame completes, nothing further starts
        sample_in = 8'hC3; gain = 8'hFF;
        wait_ack("en_drop", 2 * SD, n);
        falls0 = cs_falls;
        repeat (40) @(negedge clk);
        enable = 1'b0;
        wait_busy_done("en_drop", 400);
        chk("en_drop_frame", {16'd0, last_frame}, 32'h3C30);
        repeat (600) @(negedge clk);
        chk("en_drop_no_new_frame", cs_falls - falls0, 0);
        chk("main_no_overrun", {31'd0, overrun}, 0);

        // Overrun instance: second tick lands 100 cycles into a 132-cycle frame
        chk("ovr_initial", {31'd0, ovr2}, 0);
        base2 = acks2;
        w = frames2;
        enable2 = 1'b1;
        n = 0;
        while (frames2 == w && n < 300) begin @(negedge clk); n++; end
        if (frames2 == w) begin
            checks++; errors++;
            $display("FAIL ovr_frame_done: no frame within 300 cycles");
        end
        enable2 = 1'b0;
        chk("ovr_sticky", {31'd0, ovr2}, 1);
        chk("ovr_single_ack", acks2 - base2, 1);
        chk("ovr_frame_intact", {16'd0, last2}, 32'h3810);
        chk("ovr_frame_bits", last_nbits2, 16);

        // Asynchronous reset mid-frame at T+60
        enable = 1'b1; sample_in = 8'h6E; gain = 8'hFF;
        wait_ack("pre_reset", 2 * SD, n);
        repeat (60) @(negedge clk);
        chk("sclk_before_reset", {31'd0, dac_sclk}, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_cs_n", {31'd0, dac_cs_n}, 1);
        chk("async_sclk", {31'd0, dac_sclk}, 0);
        chk("async_busy", {31'd0, busy}, 0);
        chk("async_ovr_clear", {31'd0, ovr2}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        run_frame("after_reset", 8'h12, 8'hFF, 16'h3120);
        chk("final_overrun", {31'd0, overrun}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
